// File: rtl/result_fmt_pkg.sv
// State encoding and ASCII constants shared by the result formatter blocks.
package result_fmt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        EMIT = 2'd2,
        ERR  = 2'd3
    } fmt_state_e;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_DOT  = 8'h2E;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_E    = 8'h45;
    localparam logic [7:0] ASCII_R    = 8'h52;

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter, one input bit per cycle.
// done_o rises W cycles after start_i and holds until the next start_i.
module bin2bcd_seq #(
    parameter int W      = 10,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [W-1:0]          bin_i,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]        bin_q, bin_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                run_q, run_d;
    logic                done_q, done_d;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = done_q;
        if (start_i) begin
            bin_d  = bin_i;
            bcd_d  = '0;
            cnt_d  = '0;
            run_d  = 1'b1;
            done_d = 1'b0;
        end else if (run_q) begin
            // Digits are corrected before the shift so every step stays a valid BCD doubling.
            bcd_d = {adj[4*DIGITS-2:0], bin_q[W-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/result_formatter.sv
// Formats an integer.thousandths quotient (or a divide error) as an ASCII line.
// First byte valid N+1 cycles after accept; bytes hold under out_ready=0, one word in flight.
module result_formatter
    import result_fmt_pkg::*;
#(
    parameter int SIZE       = 4,
    parameter int INT_DIGITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_m,
    input  logic [9:0]      in_f,
    input  logic            in_err,
    output logic [7:0]      out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy
);
    localparam int N     = (SIZE > 10) ? SIZE : 10;
    localparam int IDX_W = $clog2(INT_DIGITS + 6);

    fmt_state_e             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       nint, last_emit;
    logic [4*INT_DIGITS-1:0] int_bcd;
    logic [11:0]            frac_bcd;
    logic                   int_done, frac_done, start;
    logic [9:0]             f_sat;
    logic [3:0]             digit;
    logic [7:0]             emit_byte, err_byte;

    assign start = (state_q == IDLE) && in_valid;
    assign f_sat = (in_f > 10'd999) ? 10'd999 : in_f;

    bin2bcd_seq #(.W(N), .DIGITS(INT_DIGITS)) u_int_bcd (
        .clk(clk), .rst(rst), .start_i(start), .bin_i(N'(in_m)),
        .done_o(int_done), .bcd_o(int_bcd)
    );

    bin2bcd_seq #(.W(N), .DIGITS(3)) u_frac_bcd (
        .clk(clk), .rst(rst), .start_i(start), .bin_i(N'(f_sat)),
        .done_o(frac_done), .bcd_o(frac_bcd)
    );

    // nint = count of integer digits shown once leading zeros are dropped (at least one).
    always_comb begin
        nint = IDX_W'(1);
        for (int i = 1; i < INT_DIGITS; i++) begin
            if (int_bcd[4*i +: 4] != 4'd0) nint = IDX_W'(i + 1);
        end
        last_emit = nint + IDX_W'(4);
        digit     = 4'd0;
        emit_byte = ASCII_LF;
        if (idx_q < nint) begin
            for (int i = 0; i < INT_DIGITS; i++) begin
                if (IDX_W'(i) == nint - idx_q - 1'b1) digit = int_bcd[4*i +: 4];
            end
            emit_byte = ASCII_ZERO + {4'd0, digit};
        end else if (idx_q == nint) begin
            emit_byte = ASCII_DOT;
        end else if (idx_q < last_emit) begin
            for (int j = 0; j < 3; j++) begin
                if (IDX_W'(j) == nint + IDX_W'(3) - idx_q) digit = frac_bcd[4*j +: 4];
            end
            emit_byte = ASCII_ZERO + {4'd0, digit};
        end
    end

    always_comb begin
        case (idx_q[1:0])
            2'd0:    err_byte = ASCII_E;
            2'd3:    err_byte = ASCII_LF;
            default: err_byte = ASCII_R;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        out_data  = 8'h00;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (in_valid) state_d = in_err ? ERR : CONV;
            end
            CONV: begin
                if (int_done && frac_done) state_d = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_data  = emit_byte;
                if (out_ready) begin
                    if (idx_q == last_emit) state_d = IDLE;
                    else                    idx_d   = idx_q + 1'b1;
                end
            end
            ERR: begin
                out_valid = 1'b1;
                out_data  = err_byte;
                if (out_ready) begin
                    if (idx_q == IDX_W'(3)) state_d = IDLE;
                    else                    idx_d   = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_result_formatter.sv
// Directed bench for result_formatter: string model plus per-cycle output compare.
module tb_result_formatter;
    localparam int SIZE = 4;
    localparam int N    = (SIZE > 10) ? SIZE : 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_err = 1'b0;
    logic            out_ready = 1'b1;
    logic [SIZE-1:0] in_m = '0;
    logic [9:0]      in_f = '0;
    logic            in_ready, out_valid, busy;
    logic [7:0]      out_data;

    result_formatter #(.SIZE(SIZE), .INT_DIGITS(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_m(in_m), .in_f(in_f), .in_err(in_err), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0, cyc = 0, hs_cnt = 0, n_acc = 0, n_lf = 0;
    int          last_lat = -1;
    logic [63:0] got_v = '0;
    logic [7:0]  exp_q[$];
    int          edge_q[$];
    int          lat_q[$];
    bit          in_str = 1'b0, prev_rst = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Expected bytes for one accepted word, built from decimal arithmetic.
    task automatic model_push(input int m, input int f, input bit e);
        int fv, mv;
        int digs[$];
        if (e) begin
            exp_q.push_back(8'h45); exp_q.push_back(8'h52);
            exp_q.push_back(8'h52); exp_q.push_back(8'h0A);
            lat_q.push_back(0);
        end else begin
            fv = (f > 999) ? 999 : f;
            mv = m;
            do begin
                digs.push_front(mv % 10);
                mv = mv / 10;
            end while (mv > 0);
            foreach (digs[i]) exp_q.push_back(8'(48 + digs[i]));
            exp_q.push_back(8'h2E);
            exp_q.push_back(8'(48 + fv / 100));
            exp_q.push_back(8'(48 + (fv / 10) % 10));
            exp_q.push_back(8'(48 + fv % 10));
            exp_q.push_back(8'h0A);
            lat_q.push_back(N + 1);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete(); edge_q.delete(); lat_q.delete();
            in_str   = 1'b0;
            prev_rst = 1'b1;
        end else begin
            if (prev_rst) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_in_ready", in_ready, 1);
                chk("rst_busy", busy, 0);
                chk("rst_out_data", out_data, 0);
                prev_rst = 1'b0;
            end
            chk("in_ready_vs_busy", in_ready, !busy);
            if (in_str) chk("out_valid_held", out_valid, 1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL extra_byte: got %h with no byte expected", out_data);
                end else begin
                    if (!in_str) begin
                        last_lat = cyc - edge_q.pop_front();
                        chk("latency", last_lat, lat_q.pop_front());
                        in_str = 1'b1;
                    end
                    chk("byte", out_data, exp_q[0]);
                    if (out_ready) begin
                        got_v = {got_v[55:0], out_data};
                        hs_cnt++;
                        if (exp_q[0] == 8'h0A) begin
                            in_str = 1'b0;
                            n_lf++;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                n_acc++;
                edge_q.push_back(cyc + 1);
                model_push(int'(in_m), int'(in_f), in_err);
            end
        end
    end

    task automatic send(input int m, input int f, input bit e);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles", in_ready, t);
        end
        in_m = SIZE'(m); in_f = 10'(f); in_err = e; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(posedge clk); #1;
        while ((busy || exp_q.size() != 0) && t < 400) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 400) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout: busy=%b pending=%0d", busy, exp_q.size());
        end
    endtask

    task automatic run_one(input int m, input int f, input bit e);
        got_v = '0;
        send(m, f, e);
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, a0, l0;
        logic [3:0] pat;
        pat = 4'b1001;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_one(3, 333, 1'b0);
        chk("str_3.333", got_v, 64'("3.333\n"));
        chk("lat_3.333", last_lat, 11);
        run_one(0, 5, 1'b0);
        chk("str_0.005", got_v, 64'("0.005\n"));
        run_one(15, 0, 1'b0);
        chk("str_15.000", got_v, 64'("15.000\n"));
        run_one(7, 1000, 1'b0);
        chk("str_7.999", got_v, 64'("7.999\n"));
        run_one(9, 1023, 1'b0);
        chk("str_9.999", got_v, 64'("9.999\n"));
        run_one(15, 1000, 1'b1);
        chk("str_err", got_v, 64'("ERR\n"));
        chk("lat_err", last_lat, 0);

        // Stall pattern 1,0,0,1 repeated across the whole string.
        got_v = '0;
        send(15, 0, 1'b0);
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 400) begin
            out_ready = pat[t % 4];
            @(posedge clk); #1; t++;
        end
        out_ready = 1'b1;
        chk("stall_done", (t < 400), 1);
        chk("str_stall", got_v, 64'("15.000\n"));

        // Reset while the third byte is presented.
        got_v = '0; hs_cnt = 0;
        send(12, 345, 1'b0);
        t = 0;
        while (hs_cnt < 2 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        chk("rst_reach_3rd", (t < 200), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_partial", got_v, 64'h3132);
        @(posedge clk); #1;
        chk("rst_no_bytes", out_valid, 0);
        run_one(4, 56, 1'b0);
        chk("str_after_rst", got_v, 64'("4.056\n"));

        // in_valid held high: one string per IDLE visit.
        a0 = n_acc; l0 = n_lf; got_v = '0;
        in_m = 4'd2; in_f = 10'd50; in_err = 1'b0; in_valid = 1'b1;
        repeat (60) @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle();
        chk("held_strings", n_lf - l0, n_acc - a0);
        chk("held_multi", ((n_acc - a0) >= 3), 1);
        chk("held_last", got_v[47:0], 48'("2.050\n"));

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/result_formatter.md
RESULT_FORMATTER -- requirements
Module: result_formatter

Interface
REQ-001 SHALL have parameter SIZE, default 4, width of the integer quotient input.
REQ-002 SHALL have parameter INT_DIGITS, default 2, count of decimal integer digits; legal only if 10^INT_DIGITS > 2^SIZE-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  result word present.
REQ-006 in_ready  output  1  block can accept a result word.
REQ-007 in_m  input  SIZE  unsigned integer part of quotient.
REQ-008 in_f  input  10  unsigned fraction, thousandths (0..999).
REQ-009 in_err  input  1  divide-by-zero flag; in_m and in_f are ignored when set.
REQ-010 out_data  output  8  ASCII byte.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  sink accepts byte.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement the states IDLE, CONV, EMIT and ERR.
REQ-015 in_ready SHALL be high only in IDLE; a word is accepted on an edge with in_valid && in_ready.
REQ-016 On accept, the block SHALL register in_m and in_f; in_f > 999 SHALL saturate to 999.
REQ-017 Accept with in_err=1: IDLE->ERR; the byte string SHALL be "ERR\n" (0x45 0x52 0x52 0x0A).
REQ-018 Accept with in_err=0: IDLE->CONV; CONV SHALL last exactly N=max(SIZE,10) cycles of shift-add-3 binary-to-BCD conversion, one bit per cycle, on in_m and in_f in parallel; then CONV->EMIT.
REQ-019 EMIT byte string: integer digits with leading zeros suppressed (at least one digit), then '.' (0x2E), then exactly three fraction digits including leading zeros, then 0x0A.
REQ-020 Digits SHALL be encoded as 0x30 + digit.
REQ-021 Latency: for accept at edge k, out_valid SHALL first be high in the cycle after edge k+N+1.
REQ-022 While out_valid=1 and out_ready=0, out_data SHALL remain stable and out_valid SHALL stay high.
REQ-023 A byte SHALL advance only on an edge with out_valid && out_ready; bytes SHALL be emitted with no bubbles while out_ready stays high.
REQ-024 After the 0x0A byte is accepted, the FSM SHALL return to IDLE; in_ready SHALL be high on the next cycle.
REQ-025 in_valid asserted outside IDLE SHALL be ignored; no word is queued.
REQ-026 out_valid SHALL be low in IDLE and CONV.
REQ-027 Integer width SHALL reach INT_DIGITS digits with no truncation for any in_m.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE with out_valid=0, out_data=0x00, busy=0, in_ready=1 and BCD registers cleared, in any state.
REQ-029 A reset during CONV, EMIT or ERR SHALL abort the string; no further bytes are emitted.

Structure
REQ-030 Package result_fmt_pkg SHALL hold the state encoding and the ASCII constants: ASCII_ZERO, ASCII_DOT, ASCII_LF, and ASCII_E/ASCII_R.
REQ-031 Sub-module bin2bcd_seq SHALL be an iterative, parameterised shift-add-3 converter with start/done; it is instantiated twice, once for the integer part and once for the fraction.

Verification
REQ-032 m=3, f=333, out_ready=1 -> 0x33 0x2E 0x33 0x33 0x33 0x0A; first out_valid exactly 11 cycles after the accept edge.
REQ-033 m=0, f=5 -> "0.005\n"; m=15, f=0 -> "15.000\n"; f=1000 -> fraction "999".
REQ-034 in_err=1 -> "ERR\n", in_m and in_f ignored, no CONV cycles.
REQ-035 out_ready toggled 1,0,0,1 during "15.000\n" -> out_data stable while stalled, no byte lost or duplicated.
REQ-036 rst pulsed during the third EMIT byte -> out_valid=0 and in_ready=1 on the next cycle; the following word formats correctly.
REQ-037 in_valid held high throughout -> exactly one string per IDLE visit; in_valid during busy is dropped.
